// File: rtl/mtrx_loader_if.sv
// ----------------------------------------------------------------------------
// mtrx_loader_if
// Bundle of the element-stream input, the matrix-pair output handshake and
// the loader status lines of mtrx_loader.
//   clear       abort request (discard a partial load)
//   in_valid    in_data carries an element
//   in_data     signed element, two's complement
//   in_ready    loader can accept an element
//   out_valid   a_out/b_out hold a complete pair
//   out_ready   consumer takes the pair
//   a_out/b_out packed matrices, element i at [i*ELEM_W +: ELEM_W]
//   elem_count  elements accepted in the current phase
//   phase       0=LOAD_A, 1=LOAD_B, 2=HOLD
// master = stream source / pair consumer, slave = the loader.
// ----------------------------------------------------------------------------
interface mtrx_loader_if #(
   parameter int ELEM_W = 8,
   parameter int N_ELEM = 25
);
   logic                       clear;
   logic                       in_valid;
   logic [ELEM_W-1:0]          in_data;
   logic                       in_ready;
   logic                       out_valid;
   logic                       out_ready;
   logic [ELEM_W*N_ELEM-1:0]   a_out;
   logic [ELEM_W*N_ELEM-1:0]   b_out;
   logic [4:0]                 elem_count;
   logic [1:0]                 phase;

   modport master (
      output clear, in_valid, in_data, out_ready,
      input  in_ready, out_valid, a_out, b_out, elem_count, phase
   );

   modport slave (
      input  clear, in_valid, in_data, out_ready,
      output in_ready, out_valid, a_out, b_out, elem_count, phase
   );
endinterface

// File: rtl/mtrx_loader.sv
// ----------------------------------------------------------------------------
// mtrx_loader
// Collects two matrices of N_ELEM signed elements from a single valid/ready
// element stream (first A, then B) and presents them as one packed pair with
// a valid/ready handshake to a downstream subtractor.
// Ports:
//   clock  rising-edge clock
//   reset  synchronous active-high reset (clears state and matrix storage)
//   bus    mtrx_loader_if.slave (stream in, pair out, status)
// Elements are stored bit-exact; a reload overwrites slices one by one, so
// untouched slices keep their previous contents.
// ----------------------------------------------------------------------------
module mtrx_loader #(
   parameter int ELEM_W = 8,
   parameter int N_ELEM = 25
) (
   input logic          clock,
   input logic          reset,
   mtrx_loader_if.slave bus
);

   typedef enum logic [1:0] {
      LOAD_A = 2'd0,
      LOAD_B = 2'd1,
      HOLD   = 2'd2
   } state_t;

   localparam logic [4:0] LAST_IDX = 5'(N_ELEM - 1);

   state_t              state_r;
   logic [4:0]          cnt_r;
   logic                out_valid_r;
   logic                in_ready_r;
   logic [ELEM_W-1:0]   a_mem_r [N_ELEM];
   logic [ELEM_W-1:0]   b_mem_r [N_ELEM];

   // Loader FSM: phase, element counter, handshake flags and matrix storage.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r     <= LOAD_A;
         cnt_r       <= 5'd0;
         out_valid_r <= 1'b0;
         in_ready_r  <= 1'b1;
         for (int i = 0; i < N_ELEM; i++) begin
            a_mem_r[i] <= '0;
            b_mem_r[i] <= '0;
         end
      end else if (bus.clear) begin
         // Abort: restart at LOAD_A, storage left as it is.
         state_r     <= LOAD_A;
         cnt_r       <= 5'd0;
         out_valid_r <= 1'b0;
         in_ready_r  <= 1'b1;
      end else begin
         case (state_r)
            LOAD_A: begin
               if (bus.in_valid) begin
                  a_mem_r[cnt_r] <= bus.in_data;
                  if (cnt_r == LAST_IDX) begin
                     state_r <= LOAD_B;
                     cnt_r   <= 5'd0;
                  end else begin
                     cnt_r   <= cnt_r + 5'd1;
                  end
               end
            end
            LOAD_B: begin
               if (bus.in_valid) begin
                  b_mem_r[cnt_r] <= bus.in_data;
                  if (cnt_r == LAST_IDX) begin
                     // Last element of B: pair becomes valid on the next cycle.
                     state_r     <= HOLD;
                     cnt_r       <= 5'd0;
                     out_valid_r <= 1'b1;
                     in_ready_r  <= 1'b0;
                  end else begin
                     cnt_r       <= cnt_r + 5'd1;
                  end
               end
            end
            HOLD: begin
               if (bus.out_ready) begin
                  state_r     <= LOAD_A;
                  cnt_r       <= 5'd0;
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
               end
            end
            default: begin
               state_r     <= LOAD_A;
               cnt_r       <= 5'd0;
               out_valid_r <= 1'b0;
               in_ready_r  <= 1'b1;
            end
         endcase
      end
   end

   // Pack the element registers onto the flat output buses.
   for (genvar k = 0; k < N_ELEM; k++) begin : g_pack
      assign bus.a_out[k*ELEM_W +: ELEM_W] = a_mem_r[k];
      assign bus.b_out[k*ELEM_W +: ELEM_W] = b_mem_r[k];
   end

   assign bus.in_ready   = in_ready_r;
   assign bus.out_valid  = out_valid_r;
   assign bus.elem_count = cnt_r;
   assign bus.phase      = state_r;

endmodule

// File: tb/tb_mtrx_loader.sv
module tb_mtrx_loader;

   localparam int ELEM_W = 8;
   localparam int N_ELEM = 25;

   logic clock;
   logic reset;

   mtrx_loader_if #(.ELEM_W(ELEM_W), .N_ELEM(N_ELEM)) bus ();

   mtrx_loader #(.ELEM_W(ELEM_W), .N_ELEM(N_ELEM)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int total;
   int bad;

   logic [7:0]   stream [0:49];
   logic [199:0] exp_a;
   logic [199:0] exp_b;

   // out_valid pulse monitor (sampled on the falling edge)
   bit mon_en;
   int ov_cycles;
   initial ov_cycles = 0;
   always @(negedge clock) begin
      if (mon_en && bus.out_valid) ov_cycles <= ov_cycles + 1;
   end

   typedef struct {
      logic        rst;
      logic        clr;
      logic        iv;
      logic [7:0]  d;
      logic        ordy;
      logic [1:0]  ph;
      logic [4:0]  cnt;
      logic        rdy;
      logic        ov;
      logic [23:0] alo;
   } vec_t;

   vec_t tbl [8];

   task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      reset         = 1'b0;
      bus.clear     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = 8'h00;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   // Feed stream[0..n-1]; optionally an idle cycle after each accept and
   // per-accept checks of elem_count/phase.
   task automatic load(input int n, input bit gap, input bit chk_cnt);
      for (int i = 0; i < n; i++) begin
         int w;
         int ecnt;
         int eph;
         w = 0;
         while (!bus.in_ready && w < 10) begin
            idle();
            tick();
            w++;
         end
         if (!bus.in_ready) begin
            chk("ready_timeout", {199'd0, bus.in_ready}, {199'd0, 1'b1});
            return;
         end
         bus.in_valid = 1'b1;
         bus.in_data  = stream[i];
         tick();
         bus.in_valid = 1'b0;
         ecnt = (i == 24 || i == 49) ? 0 : (i % 25) + 1;
         eph  = (i < 24) ? 0 : ((i < 49) ? 1 : 2);
         if (chk_cnt) begin
            chk($sformatf("cnt_acc%0d", i), {195'd0, bus.elem_count}, 200'(ecnt));
            chk($sformatf("ph_acc%0d", i), {198'd0, bus.phase}, 200'(eph));
         end
         if (gap) begin
            tick();
            if (chk_cnt) chk($sformatf("cnt_gap%0d", i), {195'd0, bus.elem_count}, 200'(ecnt));
         end
      end
   endtask

   task automatic fill_counting();
      for (int k = 0; k < 25; k++) begin
         stream[k]      = 8'(k + 2);
         stream[k + 25] = 8'(25 - k);
         exp_a[k*8 +: 8] = 8'(k + 2);
         exp_b[k*8 +: 8] = 8'(25 - k);
      end
   endtask

   initial begin
      total         = 0;
      bad           = 0;
      mon_en        = 1'b0;
      bus.out_ready = 1'b0;
      idle();
      reset = 1'b1;
      tick();
      tick();

      // rst clr iv data ordy | phase cnt rdy ov a_out[23:0]
      tbl[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 5'd0, 1'b1, 1'b0, 24'h000000};
      tbl[1] = '{1'b0, 1'b0, 1'b1, 8'h05, 1'b0, 2'd0, 5'd1, 1'b1, 1'b0, 24'h000005};
      tbl[2] = '{1'b0, 1'b0, 1'b0, 8'h99, 1'b0, 2'd0, 5'd1, 1'b1, 1'b0, 24'h000005};
      tbl[3] = '{1'b0, 1'b0, 1'b1, 8'hFD, 1'b0, 2'd0, 5'd2, 1'b1, 1'b0, 24'h00FD05};
      tbl[4] = '{1'b0, 1'b1, 1'b1, 8'h7F, 1'b0, 2'd0, 5'd0, 1'b1, 1'b0, 24'h00FD05};
      tbl[5] = '{1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 2'd0, 5'd1, 1'b1, 1'b0, 24'h00FD11};
      tbl[6] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 2'd0, 5'd1, 1'b1, 1'b0, 24'h00FD11};
      tbl[7] = '{1'b1, 1'b1, 1'b1, 8'h42, 1'b1, 2'd0, 5'd0, 1'b1, 1'b0, 24'h000000};

      for (int i = 0; i < 8; i++) begin
         reset         = tbl[i].rst;
         bus.clear     = tbl[i].clr;
         bus.in_valid  = tbl[i].iv;
         bus.in_data   = tbl[i].d;
         bus.out_ready = tbl[i].ordy;
         tick();
         chk($sformatf("v%0d_phase", i), {198'd0, bus.phase}, {198'd0, tbl[i].ph});
         chk($sformatf("v%0d_cnt", i), {195'd0, bus.elem_count}, {195'd0, tbl[i].cnt});
         chk($sformatf("v%0d_rdy", i), {199'd0, bus.in_ready}, {199'd0, tbl[i].rdy});
         chk($sformatf("v%0d_ov", i), {199'd0, bus.out_valid}, {199'd0, tbl[i].ov});
         chk($sformatf("v%0d_alo", i), {176'd0, bus.a_out[23:0]}, {176'd0, tbl[i].alo});
      end
      idle();
      bus.out_ready = 1'b0;

      // Counting stream, in_valid held high
      fill_counting();
      do_reset();
      load(50, 1'b0, 1'b1);
      chk("full_ov", {199'd0, bus.out_valid}, {199'd0, 1'b1});
      chk("full_rdy", {199'd0, bus.in_ready}, 200'd0);
      chk("full_a", bus.a_out, exp_a);
      chk("full_b", bus.b_out, exp_b);

      // Hold for 5 cycles with junk offered on the stream, then release
      for (int c = 0; c < 5; c++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 8'h55;
         tick();
         chk($sformatf("hold%0d_ov", c), {199'd0, bus.out_valid}, {199'd0, 1'b1});
         chk($sformatf("hold%0d_rdy", c), {199'd0, bus.in_ready}, 200'd0);
         chk($sformatf("hold%0d_a", c), bus.a_out, exp_a);
         chk($sformatf("hold%0d_b", c), bus.b_out, exp_b);
      end
      idle();
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk("rel_phase", {198'd0, bus.phase}, 200'd0);
      chk("rel_rdy", {199'd0, bus.in_ready}, {199'd0, 1'b1});
      chk("rel_ov", {199'd0, bus.out_valid}, 200'd0);
      chk("rel_cnt", {195'd0, bus.elem_count}, 200'd0);

      // Same stream with idle cycles in between
      do_reset();
      load(50, 1'b1, 1'b1);
      chk("gap_ov", {199'd0, bus.out_valid}, {199'd0, 1'b1});
      chk("gap_a", bus.a_out, exp_a);
      chk("gap_b", bus.b_out, exp_b);

      // Clear after 10 elements, colliding with an element
      do_reset();
      load(10, 1'b0, 1'b0);
      bus.clear    = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h7F;
      tick();
      idle();
      chk("clr_phase", {198'd0, bus.phase}, 200'd0);
      chk("clr_cnt", {195'd0, bus.elem_count}, 200'd0);
      chk("clr_slice10", {192'd0, bus.a_out[80 +: 8]}, 200'd0);
      chk("clr_keep", {120'd0, bus.a_out[79:0]}, {120'd0, exp_a[79:0]});

      // Reset in the middle of B
      do_reset();
      load(30, 1'b0, 1'b0);
      chk("mid_phase", {198'd0, bus.phase}, 200'd1);
      chk("mid_cnt", {195'd0, bus.elem_count}, 200'd5);
      reset        = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h33;
      tick();
      idle();
      chk("rst_a", bus.a_out, 200'd0);
      chk("rst_b", bus.b_out, 200'd0);
      chk("rst_ov", {199'd0, bus.out_valid}, 200'd0);
      chk("rst_phase", {198'd0, bus.phase}, 200'd0);
      chk("rst_rdy", {199'd0, bus.in_ready}, {199'd0, 1'b1});

      // Two back-to-back pairs with out_ready tied high
      do_reset();
      bus.out_ready = 1'b1;
      mon_en        = 1'b1;
      load(50, 1'b0, 1'b0);
      chk("p1_ov", {199'd0, bus.out_valid}, {199'd0, 1'b1});
      chk("p1_a", bus.a_out, exp_a);
      for (int k = 0; k < 25; k++) begin
         stream[k]       = 8'hFF;
         stream[k + 25]  = 8'h80;
         exp_a[k*8 +: 8] = 8'hFF;
         exp_b[k*8 +: 8] = 8'h80;
      end
      load(50, 1'b0, 1'b0);
      chk("p2_ov", {199'd0, bus.out_valid}, {199'd0, 1'b1});
      chk("p2_a", bus.a_out, exp_a);
      chk("p2_b", bus.b_out, exp_b);
      idle();
      tick();
      chk("p2_ov_drop", {199'd0, bus.out_valid}, 200'd0);
      tick();
      mon_en = 1'b0;
      bus.out_ready = 1'b0;
      chk("ov_cycles", 200'(ov_cycles), 200'd2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
